// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage with a single-outstanding req/ack data port.
// Aligns stores, extracts/extends loads, flags misalignment, registers the write-back result.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_wen,
  input  logic [4:0]  in_reg_waddr,
  input  logic [63:0] in_alu_res,
  input  logic [63:0] in_store_data,
  input  logic        in_ld,
  input  logic        in_st,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic        in_ebreak,
  input  logic [63:0] in_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_wen,
  output logic [4:0]  wb_reg_waddr,
  output logic [63:0] wb_reg_wdata,
  output logic        wb_misalign,
  output logic        wb_ebreak,
  output logic [63:0] wb_pc
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q;
  logic        wen_q, ld_q, st_q, uns_q, ebreak_q;
  logic [4:0]  waddr_q;
  logic [63:0] alu_q, sdata_q, pc_q;
  logic [1:0]  size_q;
  logic        wb_valid_q, wb_wen_q, wb_mis_q, wb_ebreak_q;
  logic [4:0]  wb_waddr_q;
  logic [63:0] wb_wdata_q, wb_pc_q;
  logic        mis, busy;
  logic [2:0]  off_q;
  logic [63:0] sh, ld_val;
  logic [7:0]  base;
  assign busy  = state_q == BUSY;
  assign off_q = alu_q[2:0];
  assign mis   = (in_size == 2'd1 && in_alu_res[0]) || (in_size == 2'd2 && |in_alu_res[1:0]) ||
                 (in_size == 2'd3 && |in_alu_res[2:0]);
  always_comb begin
    sh     = dmem_rdata >> {off_q, 3'b000};
    base   = size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0F : 8'hFF;
    ld_val = size_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} :
             size_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
             size_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
  end
  assign in_ready   = ~busy;
  assign dmem_req   = busy;
  assign dmem_we    = busy & st_q;
  assign dmem_addr  = busy ? {alu_q[63:3], 3'b000} : 64'd0;
  assign dmem_wdata = busy && st_q ? sdata_q << {off_q, 3'b000} : 64'd0;
  assign dmem_wmask = busy && st_q ? base << off_q : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      {wen_q, ld_q, st_q, uns_q, ebreak_q} <= '0;
      waddr_q     <= '0;
      alu_q       <= '0;
      sdata_q     <= '0;
      pc_q        <= '0;
      size_q      <= '0;
      {wb_valid_q, wb_wen_q, wb_mis_q, wb_ebreak_q} <= '0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      wb_pc_q     <= 64'h0000_0000_8000_0000;
    end else begin
      wb_valid_q <= 1'b0;
      if (!busy && in_valid) begin
        {wen_q, ld_q, st_q, uns_q, ebreak_q} <= {in_reg_wen, in_ld, in_st, in_unsigned, in_ebreak};
        waddr_q <= in_reg_waddr;
        alu_q   <= in_alu_res;
        sdata_q <= in_store_data;
        pc_q    <= in_pc;
        size_q  <= in_size;
        if (!(in_ld || in_st) || mis) begin
          wb_valid_q  <= 1'b1;
          wb_wen_q    <= in_reg_wen & ~mis;
          wb_waddr_q  <= in_reg_waddr;
          wb_wdata_q  <= in_alu_res;
          wb_mis_q    <= mis;
          wb_ebreak_q <= in_ebreak;
          wb_pc_q     <= in_pc;
        end else
          state_q <= BUSY;
      end else if (busy && dmem_ack) begin
        state_q     <= IDLE;
        wb_valid_q  <= 1'b1;
        wb_wen_q    <= wen_q;
        wb_waddr_q  <= waddr_q;
        wb_wdata_q  <= ld_q ? ld_val : alu_q;
        wb_mis_q    <= 1'b0;
        wb_ebreak_q <= ebreak_q;
        wb_pc_q     <= pc_q;
      end
    end
  end
  assign wb_valid     = wb_valid_q;
  assign wb_reg_wen   = wb_wen_q;
  assign wb_reg_waddr = wb_waddr_q;
  assign wb_reg_wdata = wb_wdata_q;
  assign wb_misalign  = wb_mis_q;
  assign wb_ebreak    = wb_ebreak_q;
  assign wb_pc        = wb_pc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed expectations for mem_stage.
module tb_mem_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, in_reg_wen = 0, in_ld = 0, in_st = 0, in_unsigned = 0, in_ebreak = 0;
  logic [4:0]  in_reg_waddr = 0;
  logic [63:0] in_alu_res = 0, in_store_data = 0, in_pc = 0;
  logic [1:0]  in_size = 0;
  logic        dmem_req, dmem_we, dmem_ack = 0;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [7:0]  dmem_wmask;
  logic        wb_valid, wb_reg_wen, wb_misalign, wb_ebreak;
  logic [4:0]  wb_reg_waddr;
  logic [63:0] wb_reg_wdata, wb_pc;
  int n_cmp = 0, n_err = 0;
  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_reg_wen(in_reg_wen),
    .in_reg_waddr(in_reg_waddr), .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_ld(in_ld), .in_st(in_st), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_ebreak(in_ebreak), .in_pc(in_pc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_wen(wb_reg_wen),
    .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata), .wb_misalign(wb_misalign),
    .wb_ebreak(wb_ebreak), .wb_pc(wb_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic ld, input logic st,
                       input logic [1:0] sz, input logic uns, input logic wen, input logic [4:0] wa);
    in_valid = 1; in_alu_res = alu; in_store_data = sd; in_ld = ld; in_st = st;
    in_size = sz; in_unsigned = uns; in_reg_wen = wen; in_reg_waddr = wa; in_ebreak = 0; in_pc = 64'h200;
  endtask
  task automatic idle_in();
    in_valid = 0; in_ld = 0; in_st = 0;
  endtask
  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_wbvalid", wb_valid, 0);
    chk("rst_wbpc", wb_pc, 64'h8000_0000);
    chk("rst_wdata", wb_reg_wdata, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wmask", dmem_wmask, 0);
    rst = 0;
    // ALU pass-through with ebreak/pc
    issue(64'h1234, 0, 0, 0, 0, 0, 1, 5); in_ebreak = 1; in_pc = 64'h100;
    @(negedge clk); idle_in(); in_ebreak = 0;
    chk("alu_valid", wb_valid, 1);
    chk("alu_wdata", wb_reg_wdata, 64'h1234);
    chk("alu_waddr", wb_reg_waddr, 5);
    chk("alu_wen", wb_reg_wen, 1);
    chk("alu_ebreak", wb_ebreak, 1);
    chk("alu_pc", wb_pc, 64'h100);
    chk("alu_noreq", dmem_req, 0);
    @(negedge clk);
    chk("alu_pulse_end", wb_valid, 0);
    chk("alu_hold", wb_reg_wdata, 64'h1234);
    // ack in IDLE ignored
    dmem_ack = 1; @(negedge clk); dmem_ack = 0;
    chk("idle_ack", wb_valid, 0);
    // signed byte load, ack after 3 cycles
    issue(64'h8000_0003, 0, 1, 0, 0, 0, 1, 7); dmem_rdata = 64'h0000_0000_8000_0000;
    @(negedge clk); idle_in();
    chk("lb_req1", dmem_req, 1);
    chk("lb_addr", dmem_addr, 64'h8000_0000);
    chk("lb_we", dmem_we, 0);
    chk("lb_wmask", dmem_wmask, 0);
    chk("lb_ready", in_ready, 0);
    @(negedge clk); chk("lb_req2", dmem_req, 1); chk("lb_novalid", wb_valid, 0);
    @(negedge clk); chk("lb_req3", dmem_req, 1); dmem_ack = 1;
    @(negedge clk); dmem_ack = 0;
    chk("lb_valid", wb_valid, 1);
    chk("lb_wdata", wb_reg_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_waddr", wb_reg_waddr, 7);
    chk("lb_ready_back", in_ready, 1);
    chk("lb_req_off", dmem_req, 0);
    // unsigned byte load, ack in same cycle as request
    issue(64'h8000_0003, 0, 1, 0, 0, 1, 1, 7);
    @(negedge clk); idle_in(); dmem_ack = 1;
    @(negedge clk); dmem_ack = 0;
    chk("lbu_wdata", wb_reg_wdata, 64'h80);
    chk("lbu_valid", wb_valid, 1);
    // signed half load at offset 6
    issue(64'h4006, 0, 1, 0, 1, 0, 1, 9); dmem_rdata = 64'h8001_0000_0000_0000;
    @(negedge clk); idle_in(); dmem_ack = 1;
    @(negedge clk); dmem_ack = 0;
    chk("lh_wdata", wb_reg_wdata, 64'hFFFF_FFFF_FFFF_8001);
    // word store
    issue(64'h1004, 64'hDEADBEEF, 0, 1, 2, 0, 0, 0);
    @(negedge clk); idle_in();
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 64'h1000);
    chk("sw_wmask", dmem_wmask, 8'hF0);
    chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_0000_0000);
    dmem_ack = 1;
    @(negedge clk); dmem_ack = 0;
    chk("sw_valid", wb_valid, 1);
    chk("sw_wen", wb_reg_wen, 0);
    chk("sw_wbdata", wb_reg_wdata, 64'h1004);
    // misaligned half load
    issue(64'h2001, 0, 1, 0, 1, 0, 1, 3);
    @(negedge clk); idle_in();
    chk("mis_noreq", dmem_req, 0);
    chk("mis_valid", wb_valid, 1);
    chk("mis_flag", wb_misalign, 1);
    chk("mis_wen", wb_reg_wen, 0);
    chk("mis_ready", in_ready, 1);
    // load then ALU op with in_valid held
    issue(64'h3000, 0, 1, 0, 3, 0, 1, 10); dmem_rdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("b2b_flag_clr", wb_misalign, 1);
    issue(64'h55, 0, 0, 0, 0, 0, 1, 11);
    chk("b2b_ready1", in_ready, 0);
    @(negedge clk); chk("b2b_ready2", in_ready, 0); chk("b2b_nov", wb_valid, 0); dmem_ack = 1;
    @(negedge clk); dmem_ack = 0;
    chk("b2b_ld_valid", wb_valid, 1);
    chk("b2b_ld_wdata", wb_reg_wdata, 64'h1122_3344_5566_7788);
    chk("b2b_ld_mis", wb_misalign, 0);
    chk("b2b_ready3", in_ready, 1);
    @(negedge clk); idle_in();
    chk("b2b_alu_valid", wb_valid, 1);
    chk("b2b_alu_wdata", wb_reg_wdata, 64'h55);
    chk("b2b_alu_waddr", wb_reg_waddr, 11);
    @(negedge clk);
    chk("b2b_end", wb_valid, 0);
    // reset while BUSY with ack in the same cycle
    issue(64'h5000, 0, 1, 0, 3, 0, 1, 4);
    @(negedge clk); idle_in();
    chk("rb_req", dmem_req, 1);
    rst = 1; dmem_ack = 1;
    @(negedge clk); rst = 0; dmem_ack = 0;
    chk("rb_valid", wb_valid, 0);
    chk("rb_ready", in_ready, 1);
    chk("rb_pc", wb_pc, 64'h8000_0000);
    chk("rb_req_off", dmem_req, 0);
    chk("rb_wdata", wb_reg_wdata, 0);
    @(negedge clk);
    chk("rb_after", wb_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
